// File: rtl/alu_result_stage.sv
// ALU result stage: computes zero/carry/overflow flags and buffers results in a 2-entry FIFO.
// Optional sticky overflow trap enabled with `define ALU_RESULT_OVF_TRAP_EN.
module alu_result_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_result,
    input  logic        in_carry,
    input  logic        in_a_msb,
    input  logic        in_b_msb,
    input  logic [2:0]  in_op,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic        out_carry,
    output logic        out_ovf,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        clr_trap,
    output logic        ovf_trap
);

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        carry;
        logic        ovf;
    } entryT;

    entryT      mem [2];
    entryT      newEntry;
    entryT      headEntry;
    logic [1:0] count;
    logic       wrPtr;
    logic       rdPtr;
    logic       push;
    logic       pop;
    logic       isArith;
    logic       bEff;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Subtract overflow is judged against the inverted B operand sign.
    always_comb begin
        isArith         = (in_op == 3'd0) || (in_op == 3'd1);
        bEff            = (in_op == 3'd1) ? ~in_b_msb : in_b_msb;
        newEntry        = '0;
        newEntry.result = in_result;
        newEntry.zero   = (in_result == 32'd0);
        newEntry.carry  = isArith && in_carry;
        newEntry.ovf    = isArith && (in_a_msb == bEff) && (in_result[31] != in_a_msb);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= newEntry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        headEntry  = mem[rdPtr];
        out_result = '0;
        out_zero   = 1'b0;
        out_carry  = 1'b0;
        out_ovf    = 1'b0;
        if (out_valid) begin
            out_result = headEntry.result;
            out_zero   = headEntry.zero;
            out_carry  = headEntry.carry;
            out_ovf    = headEntry.ovf;
        end
    end

`ifdef ALU_RESULT_OVF_TRAP_EN
    // Setting on an overflowing pop takes priority over a concurrent clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_trap <= 1'b0;
        end else if (pop && headEntry.ovf) begin
            ovf_trap <= 1'b1;
        end else if (clr_trap) begin
            ovf_trap <= 1'b0;
        end
    end
`else
    logic unusedClrTrap;
    assign unusedClrTrap = clr_trap;
    assign ovf_trap      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage; trap checks follow ALU_RESULT_OVF_TRAP_EN.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_result;
    logic        in_carry;
    logic        in_a_msb;
    logic        in_b_msb;
    logic [2:0]  in_op;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_carry;
    logic        out_ovf;
    logic        out_valid;
    logic        out_ready;
    logic        clr_trap;
    logic        ovf_trap;

    int checks   = 0;
    int failures = 0;

    alu_result_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_result (in_result),
        .in_carry  (in_carry),
        .in_a_msb  (in_a_msb),
        .in_b_msb  (in_b_msb),
        .in_op     (in_op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_result(out_result),
        .out_zero  (out_zero),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clr_trap  (clr_trap),
        .ovf_trap  (ovf_trap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] res, input logic c, input logic a,
                         input logic b, input logic [2:0] op);
        in_valid  = 1'b1;
        in_result = res;
        in_carry  = c;
        in_a_msb  = a;
        in_b_msb  = b;
        in_op     = op;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if ({out_result, out_zero, out_carry, out_ovf} !== 35'd0) begin
            failures++; $display("[TB] FAIL reset_outputs: got %h/%b%b%b expected 0", out_result, out_zero, out_carry, out_ovf);
        end
        checks++;
        if (ovf_trap !== 1'b0) begin failures++; $display("[TB] FAIL reset_trap: got %b expected 0", ovf_trap); end
    endtask

    task automatic test_add_ovf();
        out_ready = 1'b1;
        drive(32'h8000_0000, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL add_valid: got %b expected 1", out_valid); end
        checks++;
        if ({out_ovf, out_zero, out_carry} !== 3'b100) begin
            failures++; $display("[TB] FAIL add_flags ovf/zero/carry: got %b%b%b expected 100", out_ovf, out_zero, out_carry);
        end
        checks++;
        if (out_result !== 32'h8000_0000) begin failures++; $display("[TB] FAIL add_result: got %h expected 80000000", out_result); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'd0 || out_ovf !== 1'b0) begin
            failures++; $display("[TB] FAIL add_drained: got valid=%b result=%h ovf=%b expected 0/0/0", out_valid, out_result, out_ovf);
        end
        clr_trap = 1'b1;
        tick();
        clr_trap = 1'b0;
    endtask

    task automatic test_sub_flags();
        out_ready = 1'b1;
        drive(32'd0, 1'b1, 1'b0, 1'b0, 3'd1);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_zero, out_carry, out_ovf} !== 4'b1110) begin
            failures++; $display("[TB] FAIL sub_flags valid/zero/carry/ovf: got %b%b%b%b expected 1110", out_valid, out_zero, out_carry, out_ovf);
        end
        tick();
        drive(32'd0, 1'b1, 1'b0, 1'b0, 3'd2);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_zero, out_carry, out_ovf} !== 4'b1100) begin
            failures++; $display("[TB] FAIL xor_flags valid/zero/carry/ovf: got %b%b%b%b expected 1100", out_valid, out_zero, out_carry, out_ovf);
        end
        tick();
        // Subtract overflow: 0x80000000 - 1 = 0x7FFFFFFF, a=1, b=0.
        drive(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 3'd1);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_ovf !== 1'b1) begin failures++; $display("[TB] FAIL sub_ovf: got %b expected 1", out_ovf); end
        tick();
        clr_trap = 1'b1;
        tick();
        clr_trap = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(32'd1, 1'b0, 1'b0, 1'b0, 3'd4);
        tick();
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready_after1: got %b expected 1", in_ready); end
        in_result = 32'd2;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready_after2: got %b expected 0", in_ready); end
        in_result = 32'd3;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd1 || in_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL b2b_hold: got valid=%b result=%0d ready=%b expected 1/1/0", out_valid, out_result, in_ready);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_result !== 32'd2) begin failures++; $display("[TB] FAIL b2b_second: got %0d expected 2", out_result); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_result !== 32'd3) begin failures++; $display("[TB] FAIL b2b_third: got %0d expected 3", out_result); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_stream();
        out_ready = 1'b0;
        drive(32'd100, 1'b0, 1'b0, 1'b0, 3'd7);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_result = 32'd101 + 32'(i);
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== 32'd101 + 32'(i)) begin
                failures++;
                $display("[TB] FAIL stream_%0d: got valid=%b ready=%b result=%0d expected 1/1/%0d", i, out_valid, in_ready, out_result, 101 + i);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(32'h8000_0000, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_full: got %b expected 0", in_ready); end
        out_ready = 1'b1;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_trap !== 1'b0) begin
            failures++; $display("[TB] FAIL rstmid_state: got valid=%b ready=%b trap=%b expected 0/1/0", out_valid, in_ready, ovf_trap);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || ovf_trap !== 1'b0) begin
            failures++; $display("[TB] FAIL rstmid_push_ignored: got valid=%b trap=%b expected 0/0", out_valid, ovf_trap);
        end
    endtask

`ifdef ALU_RESULT_OVF_TRAP_EN
    task automatic test_trap();
        out_ready = 1'b1;
        drive(32'h8000_0000, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (ovf_trap !== 1'b0) begin failures++; $display("[TB] FAIL trap_before_pop: got %b expected 0", ovf_trap); end
        tick();
        checks++;
        if (ovf_trap !== 1'b1) begin failures++; $display("[TB] FAIL trap_set: got %b expected 1", ovf_trap); end
        tick();
        checks++;
        if (ovf_trap !== 1'b1) begin failures++; $display("[TB] FAIL trap_sticky: got %b expected 1", ovf_trap); end
        drive(32'h8000_0000, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        in_valid = 1'b0;
        clr_trap = 1'b1;
        tick();
        checks++;
        if (ovf_trap !== 1'b1) begin failures++; $display("[TB] FAIL trap_set_wins: got %b expected 1", ovf_trap); end
        tick();
        clr_trap = 1'b0;
        checks++;
        if (ovf_trap !== 1'b0) begin failures++; $display("[TB] FAIL trap_clear: got %b expected 0", ovf_trap); end
    endtask
`else
    task automatic test_trap();
        out_ready = 1'b1;
        drive(32'h8000_0000, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (ovf_trap !== 1'b0) begin failures++; $display("[TB] FAIL trap_disabled: got %b expected 0", ovf_trap); end
        clr_trap = 1'b1;
        tick();
        clr_trap = 1'b0;
        checks++;
        if (ovf_trap !== 1'b0) begin failures++; $display("[TB] FAIL trap_disabled_clr: got %b expected 0", ovf_trap); end
    endtask
`endif

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_carry  = 1'b0;
        in_a_msb  = 1'b0;
        in_b_msb  = 1'b0;
        in_op     = 3'd0;
        out_ready = 1'b0;
        clr_trap  = 1'b0;
        #2;
        test_reset();
        test_add_ovf();
        test_sub_flags();
        test_back_to_back();
        test_stream();
        test_trap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_result, input, 32, ALU bit-slice mux outputs, bit 31 = MSB slice.
REQ-004 SHALL have port in_carry, input, 1, addCarryout of MSB slice.
REQ-005 SHALL have port in_a_msb / in_b_msb, input, 1 each, raw operand bit 31 (before any subtract inversion).
REQ-006 SHALL have port in_op, input, 3, function selector: 0 add, 1 sub, 2 xor, 3 slt, 4 and, 5 nand, 6 nor, 7 or.
REQ-007 SHALL have port in_valid, input, 1, and in_ready, output, 1: upstream handshake.
REQ-008 SHALL have ports out_result (32), out_zero, out_carry, out_ovf (1 each), output, plus out_valid output and out_ready input: downstream handshake.
REQ-009 SHALL have ports clr_trap, input, 1, and ovf_trap, output, 1 (see Configuration).

Function
REQ-010 SHALL transfer an input when in_valid and in_ready are both high at a rising edge; SHALL transfer an output when out_valid and out_ready are both high.
REQ-011 SHALL buffer up to 2 entries in a FIFO; in_ready = (count < 2), purely from registered state.
REQ-012 SHALL compute flags at push time: zero = (in_result == 0); carry = in_carry if in_op in {0,1}, else 0.
REQ-013 SHALL compute ovf for in_op=0 as (a_msb == b_msb) and (in_result[31] != a_msb); for in_op=1 with b_msb inverted; for all other ops 0.
REQ-014 SHALL present the head entry on out_* with out_valid = (count > 0); latency from accepted input to out_valid = 1 cycle when empty.
REQ-015 SHALL hold out_* stable while out_valid is high and out_ready is low.
REQ-016 SHALL, on simultaneous push and pop with count=1, keep count=1 and present the new entry next cycle; with count=2 no push occurs (in_ready low).
REQ-017 SHALL preserve order (FIFO); pointers wrap modulo 2.
REQ-018 SHALL drive out_result/flags to 0 when out_valid is low.

Reset
REQ-019 SHALL, when reset is high at a rising edge, set count=0, pointers=0, out_valid=0, all out_* flags and out_result=0, ovf_trap=0, in_ready=1 next cycle.
REQ-020 SHALL discard buffered entries on reset mid-operation; a push in the reset cycle SHALL be ignored.

Configuration
REQ-021 SHALL, with macro ALU_RESULT_OVF_TRAP_EN defined, set ovf_trap (sticky) in the cycle after an entry with ovf=1 is popped; clr_trap clears it; set wins over simultaneous clr_trap.
REQ-022 SHALL, without ALU_RESULT_OVF_TRAP_EN, tie ovf_trap to 0 and ignore clr_trap.

Verification
REQ-023 SHALL cover: add 0x7FFFFFFF+1 (in_result=0x80000000, a_msb=0, b_msb=0, op=0), out_ready=1 -> next cycle out_valid=1, out_ovf=1, out_zero=0.
REQ-024 SHALL cover: sub with in_result=0, in_carry=1, op=1 -> out_zero=1, out_carry=1, out_ovf=0; same values op=2 -> out_carry=0.
REQ-025 SHALL cover: out_ready=0, push 3 entries back-to-back -> in_ready low after 2nd, 3rd held; release out_ready -> entries emerge in order 1,2,3.
REQ-026 SHALL cover: count=1, simultaneous push/pop for 10 cycles -> throughput 1/cycle, count stays 1, no drops.
REQ-027 SHALL cover: count=2, reset asserted -> next cycle out_valid=0, in_ready=1, ovf_trap=0.
REQ-028 SHALL cover (ALU_RESULT_OVF_TRAP_EN): pop ovf entry -> ovf_trap=1 next cycle, persists; clr_trap with concurrent ovf pop -> stays 1; clr_trap alone -> 0.
